// File: rtl/jogo_pkg.sv
// Shared definitions for the automatic memory-game player:
// state codes shown on the hexa7seg display, interface width and a one-hot test.
package jogo_pkg;

  localparam int LARGURA = 4;

  localparam logic [3:0] COD_IDLE       = 4'h0;
  localparam logic [3:0] COD_INICIA     = 4'h1;
  localparam logic [3:0] COD_ESPERA_LED = 4'h2;
  localparam logic [3:0] COD_CAPTURA    = 4'h3;
  localparam logic [3:0] COD_PRESSIONA  = 4'h4;
  localparam logic [3:0] COD_INTERVALO  = 4'h5;
  localparam logic [3:0] COD_FIM        = 4'hE;
  localparam logic [3:0] COD_ERRO       = 4'hF;

  typedef enum logic [3:0] {
    ST_IDLE       = COD_IDLE,
    ST_INICIA     = COD_INICIA,
    ST_ESPERA_LED = COD_ESPERA_LED,
    ST_CAPTURA    = COD_CAPTURA,
    ST_PRESSIONA  = COD_PRESSIONA,
    ST_INTERVALO  = COD_INTERVALO,
    ST_FIM        = COD_FIM,
    ST_ERRO       = COD_ERRO
  } estado_t;

  function automatic logic eh_onehot(input logic [LARGURA-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/buffer_sequencia.sv
// Sequence buffer: small RAM with synchronous write and registered (synchronous) read.
module buffer_sequencia #(
  parameter int PROF = 16,
  parameter int LARG = 4,
  parameter int AW   = 4
) (
  input  logic            clock,
  input  logic            we,
  input  logic [AW-1:0]   wr_addr,
  input  logic [AW-1:0]   rd_addr,
  input  logic [LARG-1:0] dado_in,
  output logic [LARG-1:0] dado_out
);

  logic [LARG-1:0] mem [PROF];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[wr_addr] <= dado_in;
    end
    dado_out <= mem[rd_addr];
  end

endmodule

// File: rtl/jogador_automatico.sv
// Automatic player: records the LED flashes shown by the game each round and
// replays them as timed one-hot button presses until the game reports pronto.
module jogador_automatico
  import jogo_pkg::*;
#(
  parameter int MAX_JOGADAS  = 16,
  parameter int PRESS_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int QUIET_CYCLES = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               habilita,
  input  logic [LARGURA-1:0] leds,
  input  logic               pronto,
  output logic [LARGURA-1:0] botoes,
  output logic               jogar,
  output logic               ativo,
  output logic               erro,
  output logic [3:0]         db_estado
);

  localparam int IW = $clog2(MAX_JOGADAS);
  localparam int CW = IW + 1;
  localparam int TW = 8;

  estado_t            estado_reg, estado_next;
  logic [LARGURA-1:0] leds_r;
  logic [LARGURA-1:0] led_cap_reg, led_cap_next;
  logic [LARGURA-1:0] botoes_reg, botoes_next;
  logic [CW-1:0]      count_reg, count_next;
  logic [IW-1:0]      index_reg, index_next;
  logic [TW-1:0]      timer_reg, timer_next;
  logic               we;
  logic [IW-1:0]      rd_addr;
  logic [LARGURA-1:0] dado_out;
  logic               estado_ativo;

  buffer_sequencia #(
    .PROF (MAX_JOGADAS),
    .LARG (LARGURA),
    .AW   (IW)
  ) u_buffer (
    .clock    (clock),
    .we       (we),
    .wr_addr  (count_reg[IW-1:0]),
    .rd_addr  (rd_addr),
    .dado_in  (leds_r),
    .dado_out (dado_out)
  );

  // Address runs one entry ahead during replay so the next press is already
  // sitting in dado_out when botoes_reg is loaded on entry to PRESSIONA.
  assign rd_addr = (estado_reg == ST_PRESSIONA || estado_reg == ST_INTERVALO)
                 ? index_reg + IW'(1) : '0;

  assign estado_ativo = (estado_reg != ST_IDLE) && (estado_reg != ST_FIM) &&
                        (estado_reg != ST_ERRO);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_reg  <= ST_IDLE;
      leds_r      <= '0;
      led_cap_reg <= '0;
      botoes_reg  <= '0;
      count_reg   <= '0;
      index_reg   <= '0;
      timer_reg   <= '0;
    end else begin
      estado_reg  <= estado_next;
      leds_r      <= leds;
      led_cap_reg <= led_cap_next;
      botoes_reg  <= botoes_next;
      count_reg   <= count_next;
      index_reg   <= index_next;
      timer_reg   <= timer_next;
    end
  end

  always_comb begin
    estado_next  = estado_reg;
    led_cap_next = led_cap_reg;
    count_next   = count_reg;
    index_next   = index_reg;
    timer_next   = timer_reg;
    we           = 1'b0;

    if (!habilita) begin
      estado_next = ST_IDLE;
    end else if (pronto && estado_ativo) begin
      estado_next = ST_FIM;
    end else begin
      case (estado_reg)
        ST_IDLE: estado_next = ST_INICIA;
        ST_INICIA: begin
          count_next  = '0;
          index_next  = '0;
          timer_next  = '0;
          estado_next = ST_ESPERA_LED;
        end
        ST_ESPERA_LED: begin
          if (leds_r == '0) begin
            if (count_reg != '0) begin
              if (timer_reg == TW'(QUIET_CYCLES - 1)) begin
                timer_next  = '0;
                index_next  = '0;
                estado_next = ST_PRESSIONA;
              end else begin
                timer_next = timer_reg + TW'(1);
              end
            end
          end else if (!eh_onehot(leds_r) || count_reg == CW'(MAX_JOGADAS)) begin
            estado_next = ST_ERRO;
          end else begin
            we           = 1'b1;
            count_next   = count_reg + CW'(1);
            timer_next   = '0;
            led_cap_next = leds_r;
            estado_next  = ST_CAPTURA;
          end
        end
        ST_CAPTURA: begin
          if (leds_r == '0) begin
            estado_next = ST_ESPERA_LED;
          end else if (leds_r != led_cap_reg) begin
            estado_next = ST_ERRO;
          end
        end
        ST_PRESSIONA: begin
          if (timer_reg == TW'(PRESS_CYCLES - 1)) begin
            timer_next  = '0;
            estado_next = ST_INTERVALO;
          end else begin
            timer_next = timer_reg + TW'(1);
          end
        end
        ST_INTERVALO: begin
          if (timer_reg == TW'(GAP_CYCLES - 1)) begin
            timer_next = '0;
            if ({1'b0, index_reg} + CW'(1) < count_reg) begin
              index_next  = index_reg + IW'(1);
              estado_next = ST_PRESSIONA;
            end else begin
              count_next  = '0;
              estado_next = ST_ESPERA_LED;
            end
          end else begin
            timer_next = timer_reg + TW'(1);
          end
        end
        default: estado_next = estado_reg;
      endcase
    end

    botoes_next = '0;
    if (estado_next == ST_PRESSIONA) begin
      botoes_next = (estado_reg == ST_PRESSIONA) ? botoes_reg : dado_out;
    end
  end

  assign botoes    = botoes_reg;
  assign jogar     = (estado_reg == ST_INICIA);
  assign ativo     = estado_ativo;
  assign erro      = (estado_reg == ST_ERRO);
  assign db_estado = estado_reg;

endmodule

// File: doc/jogador_automatico.md
Name: jogador_automatico

Overview:
- Automatic player for the memory game. It sits on the opposite side of the game's botoes/leds interface, so it can drive the game top in bench and self-test setups without a human.
- It watches the game's LED output during the display phase and records each flashed LED into a small sequence buffer.
- It then replays the recorded sequence as timed button presses on the game's botoes input, and repeats this every round until the game reports pronto.

Parameters:
- MAX_JOGADAS, 16: buffer depth, i.e. the longest sequence it can record.
- PRESS_CYCLES, 4: number of cycles each button is held during replay.
- GAP_CYCLES, 4: number of cycles botoes is held at 0000 between presses.
- QUIET_CYCLES, 8: number of consecutive 0000 LED cycles after the last flash that ends the display phase.

Ports:
- clock, in, 1: single system clock, all logic rising-edge.
- reset, in, 1: asynchronous, active-low. reset=0 immediately forces all state and outputs to their reset values.
- habilita, in, 1: run enable. Level-sensitive; low aborts to IDLE from any state.
- leds, in, 4: game LED output, one-hot or 0000.
- pronto, in, 1: game finished (won or lost).
- botoes, out, 4: one-hot press or 0000; connects to the game's botoes input.
- jogar, out, 1: single-cycle start pulse to the game.
- ativo, out, 1: high in every state except IDLE, FIM and ERRO.
- erro, out, 1: sticky until IDLE.
- db_estado, out, 4: state code for the hexa7seg display.

Behaviour:
Reset values (reset=0):
- botoes=0000, jogar=0, ativo=0, erro=0, state IDLE (db_estado=0).
- Buffer count=0, replay index=0, all timers=0.

Input sampling:
- leds passes through one register stage (leds_r) before use.
- All flash detection and quiet counting operate on leds_r, giving 1 cycle of latency.

States and db_estado codes:
- IDLE (0): outputs at reset values. Moves to INICIA on habilita=1.
- INICIA (1): jogar=1 for exactly this one cycle; buffer count cleared. Moves to ESPERA_LED.
- ESPERA_LED (2):
  - leds_r one-hot: write it at buffer[count], count++, quiet timer=0, go to CAPTURA.
  - leds_r=0000 and count>0: quiet timer++. When it reaches QUIET_CYCLES, go to PRESSIONA with index=0.
  - leds_r not one-hot and not 0000: go to ERRO.
  - Write with count==MAX_JOGADAS (overflow): go to ERRO and do not write.
- CAPTURA (3):
  - Wait for leds_r=0000, then go to ESPERA_LED.
  - A change to a different nonzero value goes to ERRO.
- PRESSIONA (4): botoes=buffer[index] for PRESS_CYCLES cycles, then go to INTERVALO.
- INTERVALO (5): botoes=0000 for GAP_CYCLES cycles, then:
  - index+1<count: index++, go to PRESSIONA.
  - Otherwise: count=0, quiet timer=0, go to ESPERA_LED for the next round.
- FIM (E): ativo=0. Holds until habilita=0.
- ERRO (F): erro=1, ativo=0, botoes=0000. Holds until habilita=0.

Global priority rules:
- habilita=0 moves to IDLE next cycle from any state and clears erro.
- Otherwise, pronto=1 moves to FIM from any active state; a press in progress is truncated and botoes=0000 next cycle.
- pronto wins over a simultaneous LED event.

Other rules:
- leds is ignored in PRESSIONA and INTERVALO, because the game echoes the pressed button on leds.
- count is 5 bits (0..16) and index is 4 bits. Buffer reads are synchronous: the address is presented one cycle before PRESSIONA so botoes is valid from its first cycle.
- Exactly one botoes bit is ever high. botoes is registered, with no glitches.
- The jogar pulse is 1 cycle wide even if habilita stays high.
- Re-enabling after IDLE starts a fresh game.

Decomposition:
- Shared package jogo_pkg holds:
  - state encoding localparams (codes 0,1,2,3,4,5,E,F)
  - LED/button width (4)
  - function eh_onehot(4-bit)
- Sub-module buffer_sequencia: MAX_JOGADAS x 4 synchronous-write, synchronous-read RAM with we, wr_addr, rd_addr, dado_in, dado_out. This mirrors the game's own memory style.

Test Plan:
- Reset: reset=0 mid-PRESSIONA → botoes=0000, ativo=0, db_estado=0 immediately (asynchronous); stays in IDLE after release until habilita rises.
- Single-round replay: habilita=1 → jogar pulses 1 cycle. Then leds flashes 0001, 0100, 1000, each 3 cycles with 2-cycle gaps, followed by 8 quiet cycles → botoes outputs 0001, 0100, 1000, each 4 cycles, separated by 4 cycles of 0000.
- Growing rounds: 3 consecutive rounds of length 1, 2, 3 → each replay matches its round exactly. The buffer restarts at index 0 each round, and leds echoes during replay are ignored.
- Invalid LED: leds=0110 in ESPERA_LED → ERRO, erro=1, botoes=0000. Then habilita=0 → IDLE, erro=0.
- Overflow: 17 flashes without a quiet period → ERRO on the 17th flash; buffer entries 0..15 intact.
- Game end: pronto=1 during the 2nd PRESSIONA cycle → botoes=0000 next cycle, db_estado=E, ativo=0. Hold until habilita=0.
